// File: rtl/usb_pkg.sv
// usb_pkg: shared types and default constants for the USB read/write transaction sequencer.
package usb_pkg;
  typedef enum logic [2:0] {IDLE, A_REQ, A_WAIT, D_REQ, D_WAIT, OK, FAIL} txn_state_t;
  typedef enum logic [3:0] {
    PID_OUT   = 4'b0001,
    PID_IN    = 4'b1001,
    PID_SETUP = 4'b1101,
    PID_DATA0 = 4'b0011,
    PID_DATA1 = 4'b1011,
    PID_ACK   = 4'b0010,
    PID_NAK   = 4'b1010,
    PID_STALL = 4'b1110
  } pid_t;
  localparam logic [6:0]  DEF_DEV_ADDR    = 7'd5;
  localparam logic [3:0]  DEF_ADDR_ENDP   = 4'd4;
  localparam logic [3:0]  DEF_DATA_ENDP   = 4'd8;
  localparam logic [15:0] DEF_WDOG_CYCLES = 16'd20000;
endpackage

// File: rtl/usb_rw_txn_ctrl_if.sv
// usb_rw_txn_ctrl_if: requester and protocol-FSM signals around the transaction sequencer.
interface usb_rw_txn_ctrl_if;
  logic        req_valid;
  logic        req_read;
  logic [15:0] mem_page;
  logic [63:0] wr_data;
  logic        req_ready;
  logic        done;
  logic        success;
  logic [63:0] rd_data;
  logic        proto_free;
  logic        proto_cancel;
  logic        proto_recv_ready;
  logic [63:0] proto_data_recv;
  logic        send_in;
  logic        input_ready;
  logic [63:0] data_out;
  logic [6:0]  addr_out;
  logic [3:0]  endp_out;
  logic        got_result;
  modport master (
    input  req_valid, req_read, mem_page, wr_data,
    input  proto_free, proto_cancel, proto_recv_ready, proto_data_recv,
    output req_ready, done, success, rd_data,
    output send_in, input_ready, data_out, addr_out, endp_out, got_result
  );
  modport slave (
    output req_valid, req_read, mem_page, wr_data,
    output proto_free, proto_cancel, proto_recv_ready, proto_data_recv,
    input  req_ready, done, success, rd_data,
    input  send_in, input_ready, data_out, addr_out, endp_out, got_result
  );
endinterface

// File: rtl/usb_rw_txn_ctrl_cnt.sv
// usb_rw_txn_ctrl_cnt: generic up-counter with synchronous clear and enable.
module usb_rw_txn_ctrl_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_L,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk or negedge rst_L)
    if (!rst_L) cnt_q <= '0;
    else cnt_q <= clr_i ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/usb_rw_txn_ctrl.sv
// usb_rw_txn_ctrl: sequences a host page request into an address OUT packet followed by a data OUT/IN packet.
module usb_rw_txn_ctrl
  import usb_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR    = DEF_DEV_ADDR,
  parameter logic [3:0]  ADDR_ENDP   = DEF_ADDR_ENDP,
  parameter logic [3:0]  DATA_ENDP   = DEF_DATA_ENDP,
  parameter logic [15:0] WDOG_CYCLES = DEF_WDOG_CYCLES
) (
  input logic clk,
  input logic rst_L,
  usb_rw_txn_ctrl_if.master bus
);
  txn_state_t  state_q, state_d;
  logic        rd_q, send_in_q, input_ready_q, done_q, success_q, got_result_q;
  logic [63:0] wr_q, rd_data_q, data_out_q;
  logic [6:0]  addr_q;
  logic [3:0]  endp_q;
  logic [15:0] wdog;
  logic        waiting, live, wd, abort, take;
  assign waiting = state_q inside {A_REQ, A_WAIT, D_REQ, D_WAIT};
  // a zero watchdog marks the first cycle in a state, which doubles as launch blanking
  assign live  = wdog != 16'd0;
  assign wd    = wdog == WDOG_CYCLES - 16'd1;
  assign abort = wd || (live && bus.proto_cancel);
  assign take  = state_q == D_WAIT && state_d == OK && rd_q;
  usb_rw_txn_ctrl_cnt #(.W(16)) u_wdog (
    .clk  (clk),
    .rst_L(rst_L),
    .clr_i(state_d != state_q),
    .en_i (waiting),
    .cnt_o(wdog)
  );
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = bus.req_valid ? A_REQ : IDLE;
      A_REQ:   state_d = wd ? FAIL : bus.proto_free ? A_WAIT : A_REQ;
      A_WAIT:  state_d = abort ? FAIL : (live && bus.proto_free) ? D_REQ : A_WAIT;
      D_REQ:   state_d = wd ? FAIL : bus.proto_free ? D_WAIT : D_REQ;
      D_WAIT:  state_d = abort ? FAIL
                       : (live && (rd_q ? bus.proto_recv_ready : bus.proto_free)) ? OK : D_WAIT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state_q       <= IDLE;
      rd_q          <= 1'b0;
      wr_q          <= '0;
      send_in_q     <= 1'b0;
      input_ready_q <= 1'b0;
      done_q        <= 1'b0;
      success_q     <= 1'b0;
      got_result_q  <= 1'b0;
      rd_data_q     <= '0;
      data_out_q    <= '0;
      addr_q        <= '0;
      endp_q        <= '0;
    end else begin
      state_q       <= state_d;
      input_ready_q <= (state_q == A_REQ && state_d == A_WAIT) || (state_q == D_REQ && state_d == D_WAIT);
      done_q        <= state_d inside {OK, FAIL};
      success_q     <= state_d == OK;
      got_result_q  <= take;
      if (take) rd_data_q <= bus.proto_data_recv;
      if (state_q == IDLE && bus.req_valid) begin
        rd_q       <= bus.req_read;
        wr_q       <= bus.wr_data;
        endp_q     <= ADDR_ENDP;
        addr_q     <= DEV_ADDR;
        data_out_q <= {48'b0, bus.mem_page};
      end
      if (state_q == A_WAIT && state_d == D_REQ) begin
        send_in_q  <= rd_q;
        endp_q     <= DATA_ENDP;
        data_out_q <= rd_q ? '0 : wr_q;
      end
      if (state_d == IDLE) send_in_q <= 1'b0;
    end
  end
  assign bus.req_ready   = state_q == IDLE;
  assign bus.done        = done_q;
  assign bus.success     = success_q;
  assign bus.rd_data     = rd_data_q;
  assign bus.send_in     = send_in_q;
  assign bus.input_ready = input_ready_q;
  assign bus.data_out    = data_out_q;
  assign bus.addr_out    = addr_q;
  assign bus.endp_out    = endp_q;
  assign bus.got_result  = got_result_q;
endmodule
